sid_write_sequencer: RTL and testbench

- Script-driven controller that plays SID register writes from an external script ROM into the SID core's register bus.
- Paces writes to the SID clock-enable and waits in whole frames (50 Hz player tick), replacing a CPU-side play routine.
- Sits in the top-level next to the SID core, on the 12 MHz fabric clock.

---
 rtl/sid_write_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_sid_write_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_write_sequencer.sv
// sid_write_sequencer
//   Plays SID register writes from an external script ROM onto the SID core
//   register bus, pacing writes to the SID clock-enable and waiting in whole
//   player frames.
//
//   Script word: [23:22] op
//     00 WRITE  reg = [20:16], data = [7:0]
//     01 WAIT   n = [7:0] frames (0 = no delay)
//     10 LOOP   target = [ADDR_W-1:0]
//     11 END
//
//   Ports
//     CLK_IN      fabric clock
//     RST_IN      synchronous active-high reset
//     start       begin playback at address 0 when idle
//     stop        abort playback
//     rom_addr    script ROM address (ROM read latency is one cycle)
//     rom_data    script word
//     sid_ce      SID clock-enable, 1 cycle in every SID_CLK_DIV
//     sid_addr    SID register index
//     sid_data    SID write data
//     sid_we      write strobe, only ever high together with sid_ce
//     frame_tick  1-cycle pulse every CLK_HZ/TICK_HZ cycles
//     busy        high whenever not idle
//     done        1-cycle pulse when playback ends (END or stop)
//
//   Optional build macro SEQ_STOP_SILENCE_EN: END or stop first passes through
//   a SILENCE state that writes 0 to regs 0x04, 0x0B, 0x12, 0x18 (gates off,
//   volume 0), one write per sid_ce, before done and return to idle.
module sid_write_sequencer #(
  parameter int unsigned CLK_HZ      = 12_000_000,
  parameter int unsigned TICK_HZ     = 50,
  parameter int unsigned SID_CLK_DIV = 12,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              CLK_IN,
  input  logic              RST_IN,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic              sid_ce,
  output logic [4:0]        sid_addr,
  output logic [7:0]        sid_data,
  output logic              sid_we,
  output logic              frame_tick,
  output logic              busy,
  output logic              done
);

  localparam int unsigned FRAME_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned SW = (SID_CLK_DIV > 1) ? $clog2(SID_CLK_DIV) : 1;
  localparam int unsigned FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [SW-1:0] SID_LAST   = SW'(SID_CLK_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WRITE,
`ifdef SEQ_STOP_SILENCE_EN
    ST_SILENCE,
`endif
    ST_WAIT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        wait_cnt;
  logic              stop_pend;
  logic [SW-1:0]     sid_cnt;
  logic [SW-1:0]     sid_cnt_nxt;
  logic              ce_nxt;
  logic [FW-1:0]     frame_cnt;
  logic [FW-1:0]     frame_cnt_nxt;
  logic              tick_nxt;
`ifdef SEQ_STOP_SILENCE_EN
  logic [1:0]        sil_idx;
`endif

  logic [1:0] op;
  logic       unused_rom_bits;

  assign op              = rom_data[23:22];
  assign unused_rom_bits = ^{rom_data[21], rom_data[15:8]};
  assign rom_addr        = pc;

  // Lookahead of both dividers: sid_ce/frame_tick are registered, and sid_we
  // is registered one cycle ahead so it lands exactly on the sid_ce cycle.
  always_comb begin
    sid_cnt_nxt   = (sid_cnt == SID_LAST) ? '0 : sid_cnt + SW'(1);
    ce_nxt        = (sid_cnt_nxt == SID_LAST);
    frame_cnt_nxt = (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);
    tick_nxt      = (frame_cnt_nxt == FRAME_LAST);
  end

`ifdef SEQ_STOP_SILENCE_EN
  function automatic logic [4:0] sil_reg(input logic [1:0] idx);
    case (idx)
      2'd0:    sil_reg = 5'h04;
      2'd1:    sil_reg = 5'h0B;
      2'd2:    sil_reg = 5'h12;
      default: sil_reg = 5'h18;
    endcase
  endfunction
`endif

  // Common end-of-playback path for END and stop.
  task finish_playback();
    stop_pend <= 1'b0;
`ifdef SEQ_STOP_SILENCE_EN
    state    <= ST_SILENCE;
    sil_idx  <= '0;
    sid_addr <= sil_reg(2'd0);
    sid_data <= '0;
    sid_we   <= ce_nxt;
`else
    state <= ST_IDLE;
    busy  <= 1'b0;
    done  <= 1'b1;
    pc    <= '0;
`endif
  endtask

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state      <= ST_IDLE;
      pc         <= '0;
      wait_cnt   <= '0;
      stop_pend  <= 1'b0;
      sid_cnt    <= '0;
      frame_cnt  <= '0;
      sid_ce     <= 1'b0;
      frame_tick <= 1'b0;
      sid_addr   <= '0;
      sid_data   <= '0;
      sid_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SEQ_STOP_SILENCE_EN
      sil_idx    <= '0;
`endif
    end else begin
      sid_cnt    <= sid_cnt_nxt;
      sid_ce     <= ce_nxt;
      frame_cnt  <= frame_cnt_nxt;
      frame_tick <= tick_nxt;
      done       <= 1'b0;
      sid_we     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state <= ST_FETCH;
            busy  <= 1'b1;
            pc    <= '0;
          end
        end

        ST_FETCH: begin
          if (stop) finish_playback();
          else      state <= ST_DECODE;
        end

        ST_DECODE: begin
          if (stop) begin
            finish_playback();
          end else begin
            case (op)
              2'b00: begin
                sid_addr <= rom_data[20:16];
                sid_data <= rom_data[7:0];
                pc       <= pc + 1'b1;
                state    <= ST_WRITE;
                sid_we   <= ce_nxt;
              end
              2'b01: begin
                pc <= pc + 1'b1;
                if (rom_data[7:0] == 8'd0) begin
                  state <= ST_FETCH;
                end else begin
                  wait_cnt <= rom_data[7:0];
                  state    <= ST_WAIT;
                end
              end
              2'b10: begin
                pc    <= rom_data[ADDR_W-1:0];
                state <= ST_FETCH;
              end
              default: finish_playback();
            endcase
          end
        end

        // sid_we high here means this is the sid_ce cycle carrying the write.
        // A stop seen at any point in WRITE is held until the write issues.
        ST_WRITE: begin
          if (stop) stop_pend <= 1'b1;
          if (sid_we) begin
            if (stop || stop_pend) finish_playback();
            else                   state <= ST_FETCH;
          end else begin
            sid_we <= ce_nxt;
          end
        end

        ST_WAIT: begin
          if (stop) begin
            finish_playback();
          end else if (frame_tick) begin
            if (wait_cnt == 8'd1) state <= ST_FETCH;
            else                  wait_cnt <= wait_cnt - 8'd1;
          end
        end

`ifdef SEQ_STOP_SILENCE_EN
        ST_SILENCE: begin
          if (sid_we) begin
            if (sil_idx == 2'd3) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pc    <= '0;
            end else begin
              sil_idx  <= sil_idx + 2'd1;
              sid_addr <= sil_reg(sil_idx + 2'd1);
              sid_we   <= ce_nxt;
            end
          end else begin
            sid_we <= ce_nxt;
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sid_write_sequencer.sv
module tb_sid_write_sequencer;

  localparam int SIDDIV = 4;
  localparam int FRAME  = 120;

  logic        CLK_IN = 1'b0;
  logic        RST_IN = 1'b1;
  logic        start  = 1'b0;
  logic        stop   = 1'b0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data = '0;
  logic        sid_ce;
  logic [4:0]  sid_addr;
  logic [7:0]  sid_data;
  logic        sid_we;
  logic        frame_tick;
  logic        busy;
  logic        done;

  sid_write_sequencer #(
    .CLK_HZ(1200),
    .TICK_HZ(10),
    .SID_CLK_DIV(4),
    .ADDR_W(8)
  ) dut (
    .CLK_IN(CLK_IN),
    .RST_IN(RST_IN),
    .start(start),
    .stop(stop),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .sid_ce(sid_ce),
    .sid_addr(sid_addr),
    .sid_data(sid_data),
    .sid_we(sid_we),
    .frame_tick(frame_tick),
    .busy(busy),
    .done(done)
  );

  always #5 CLK_IN = ~CLK_IN;

  logic [23:0] rom [256];
  always @(posedge CLK_IN) rom_data <= rom[rom_addr];

  // Cycle index: 0 is the first cycle after the last reset edge.
  int cyc = 0;
  always @(posedge CLK_IN) cyc <= RST_IN ? 0 : cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  int  q_fetch[$];
  int  q_wcyc[$];
  int  model_done;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Script word builders
  function automatic logic [23:0] op_wr(input logic [4:0] a, input logic [7:0] d);
    return {2'b00, 1'b0, a, 8'h00, d};
  endfunction
  function automatic logic [23:0] op_wt(input logic [7:0] n);
    return {2'b01, 14'd0, n};
  endfunction
  function automatic logic [23:0] op_lp(input logic [7:0] t);
    return {2'b10, 14'd0, t};
  endfunction
  function automatic logic [23:0] op_end();
    return {2'b11, 22'd0};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = op_end();
  endtask

  // ---------------- reference model ----------------
  function automatic int next_ce(input int c);
    int x = c;
    while ((x % SIDDIV) != SIDDIV - 1) x++;
    return x;
  endfunction

  function automatic int next_tick(input int c);
    int x = c;
    while ((x % FRAME) != FRAME - 1) x++;
    return x;
  endfunction

  function automatic logic [4:0] silence_reg(input int i);
    case (i)
      0:       return 5'h04;
      1:       return 5'h0B;
      2:       return 5'h12;
      default: return 5'h18;
    endcase
  endfunction

  // Playback ends with the machine leaving its last busy state in cycle c.
  task automatic end_seq(input int c, input bit push);
`ifdef SEQ_STOP_SILENCE_EN
    int  w;
    wr_t e;
    w = c;
    for (int i = 0; i < 4; i++) begin
      w = next_ce(w);
      e.cyc = w; e.a = silence_reg(i); e.d = 8'h00;
      if (push) wr_q.push_back(e);
      w++;
    end
    model_done = w;
`else
    model_done = c;
`endif
    if (push) done_q.push_back(model_done);
  endtask

  // Walks the script from ROM: start sampled in cycle cs, stop pulsed in cycle
  // stop_at (-1 = none). FETCH at t, DECODE at t+1, a write lands on the first
  // sid_ce cycle strictly after DECODE, a WAIT ends on its n-th frame tick.
  task automatic model(input int cs, input int stop_at, input bit push);
    int          t;
    int          pc;
    int          c;
    int          f;
    bit          fin;
    logic [23:0] w;
    wr_t         e;
    t = cs + 1; pc = 0; fin = 1'b0; model_done = -1;
    q_fetch.delete(); q_wcyc.delete();
    for (int guard = 0; guard < 64 && !fin; guard++) begin
      q_fetch.push_back(t);
      if (stop_at == t || stop_at == t + 1) begin
        end_seq(stop_at + 1, push); fin = 1'b1;
      end else begin
        w = rom[pc];
        case (w[23:22])
          2'b00: begin
            c = next_ce(t + 2);
            q_wcyc.push_back(c);
            e.cyc = c; e.a = w[20:16]; e.d = w[7:0];
            if (push) wr_q.push_back(e);
            if (stop_at >= t + 2 && stop_at <= c) begin
              end_seq(c + 1, push); fin = 1'b1;
            end else begin
              pc = (pc + 1) % 256; t = c + 1;
            end
          end
          2'b01: begin
            if (w[7:0] == 8'd0) begin
              pc = (pc + 1) % 256; t = t + 2;
            end else begin
              f = t + 1;
              for (int k = 0; k < int'(w[7:0]); k++) f = next_tick(f + 1);
              if (stop_at >= t + 2 && stop_at <= f) begin
                end_seq(stop_at + 1, push); fin = 1'b1;
              end else begin
                pc = (pc + 1) % 256; t = f + 1;
              end
            end
          end
          2'b10: begin
            pc = int'(w[7:0]); t = t + 2;
          end
          default: begin
            end_seq(t + 2, push); fin = 1'b1;
          end
        endcase
      end
    end
  endtask

  // ---------------- monitor ----------------
  wr_t mon_e;
  int  mon_d;
  always @(negedge CLK_IN) begin
    if (mon_en) begin
      check("sid_ce_phase", int'(sid_ce), int'((cyc % SIDDIV) == SIDDIV - 1));
      check("frame_tick_phase", int'(frame_tick), int'((cyc % FRAME) == FRAME - 1));
      if (sid_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_we", int'(sid_we), 0);
        end else begin
          mon_e = wr_q.pop_front();
          check("we_cycle", cyc, mon_e.cyc);
          check("we_addr", int'(sid_addr), int'(mon_e.a));
          check("we_data", int'(sid_data), int'(mon_e.d));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", int'(done), 0);
        end else begin
          mon_d = done_q.pop_front();
          check("done_cycle", cyc, mon_d);
          check("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drain(input int budget);
    int n = 0;
    while ((wr_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      @(negedge CLK_IN);
      n++;
    end
    check("drain_writes", wr_q.size(), 0);
    check("drain_done", done_q.size(), 0);
    wr_q.delete();
    done_q.delete();
    repeat (3) @(negedge CLK_IN);
    check("idle_busy", int'(busy), 0);
  endtask

  task automatic run(input int cs, input int stop_at, input int budget);
    while (cyc < cs) @(negedge CLK_IN);
    start = 1'b1;
    @(negedge CLK_IN);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    if (stop_at >= 0) begin
      while (cyc < stop_at) @(negedge CLK_IN);
      stop = 1'b1;
      @(negedge CLK_IN);
      stop = 1'b0;
    end
    drain(budget);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_addr"}, int'(rom_addr), 0);
    check({tag, "_sid_ce"}, int'(sid_ce), 0);
    check({tag, "_sid_addr"}, int'(sid_addr), 0);
    check({tag, "_sid_data"}, int'(sid_data), 0);
    check({tag, "_sid_we"}, int'(sid_we), 0);
    check({tag, "_frame_tick"}, int'(frame_tick), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cs;
    int s;
    int dn;
    int len;
    int r;

    clear_rom();
    RST_IN = 1'b1;
    repeat (2) @(negedge CLK_IN);
    RST_IN = 1'b0;
    mon_en = 1'b1;
    check_all_zero("reset");

    // single write then END
    clear_rom();
    rom[0] = op_wr(5'h18, 8'h0F); rom[1] = op_end();
    cs = cyc + 2;
    model(cs, -1, 1'b1);
    run(cs, -1, 400);

    // back-to-back writes
    clear_rom();
    rom[0] = op_wr(5'h01, 8'h22); rom[1] = op_wr(5'h04, 8'h11); rom[2] = op_end();
    cs = cyc + 3;
    model(cs, -1, 1'b1);
    run(cs, -1, 400);

    // WAIT 2 started right after a frame tick
    clear_rom();
    rom[0] = op_wt(8'd2); rom[1] = op_wr(5'h04, 8'h41); rom[2] = op_end();
    for (int k = 0; k < 130 && (cyc % FRAME) != FRAME - 1; k++) @(negedge CLK_IN);
    cs = cyc + 1;
    model(cs, -1, 1'b1);
    run(cs, -1, 600);

    // WAIT 0 costs no frame
    clear_rom();
    rom[0] = op_wt(8'd0); rom[1] = op_wr(5'h04, 8'h41); rom[2] = op_end();
    cs = cyc + 2;
    model(cs, -1, 1'b1);
    run(cs, -1, 400);

    // endless loop, stopped in FETCH
    clear_rom();
    rom[0] = op_wr(5'h00, 8'hAA); rom[1] = op_lp(8'd0);
    cs = cyc + 2;
    model(cs, -1, 1'b0);
    s = q_fetch[5];
    model(cs, s, 1'b1);
    run(cs, s, 400);

    // stop during WRITE one cycle before sid_ce
    clear_rom();
    rom[0] = op_wr(5'h07, 8'h55); rom[1] = op_wr(5'h08, 8'h66); rom[2] = op_end();
    cs = cyc + 2;
    while (((cs + 3) % SIDDIV) == SIDDIV - 1) cs++;
    model(cs, -1, 1'b0);
    s = q_wcyc[0] - 1;
    model(cs, s, 1'b1);
    run(cs, s, 400);

    // start and stop together: nothing starts
    start = 1'b1; stop = 1'b1;
    @(negedge CLK_IN);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", int'(busy), 0);
    check("startstop_rom_addr", int'(rom_addr), 0);
    @(negedge CLK_IN);
    check("startstop_busy2", int'(busy), 0);
    check("startstop_rom_addr2", int'(rom_addr), 0);

    // reset in the middle of WAIT: pending write must never appear
    clear_rom();
    rom[0] = op_wt(8'd2); rom[1] = op_wr(5'h04, 8'h41); rom[2] = op_end();
    cs = cyc + 2;
    while (cyc < cs) @(negedge CLK_IN);
    start = 1'b1;
    @(negedge CLK_IN);
    start = 1'b0;
    repeat (10) @(negedge CLK_IN);
    check("busy_in_wait", int'(busy), 1);
    RST_IN = 1'b1;
    @(negedge CLK_IN);
    RST_IN = 1'b0;
    check_all_zero("midwait_reset");
    repeat (3) @(negedge CLK_IN);
    check("ce_after_reset", int'(sid_ce), 1);
    repeat (300) @(negedge CLK_IN);
    check("busy_after_reset", int'(busy), 0);

    // randomized scripts, some with a stop at a random point
    for (int it = 0; it < 20; it++) begin
      clear_rom();
      len = int'($urandom_range(7, 3));
      for (int i = 0; i < len - 1; i++) begin
        r = int'($urandom_range(9, 0));
        if (r < 6)
          rom[i] = op_wr(5'($urandom_range(31, 0)), 8'($urandom_range(255, 0)));
        else if (r < 8)
          rom[i] = op_wt(8'($urandom_range(2, 0)));
        else if (i + 2 <= len - 1)
          rom[i] = op_lp(8'(i + 2));
        else
          rom[i] = op_wr(5'($urandom_range(31, 0)), 8'($urandom_range(255, 0)));
      end
      rom[len - 1] = op_end();
      cs = cyc + int'($urandom_range(6, 1));
      model(cs, -1, 1'b0);
      dn = model_done;
      s = -1;
      if ($urandom_range(2, 0) == 0) s = int'($urandom_range(dn - 1, cs + 1));
      model(cs, s, 1'b1);
      run(cs, s, dn - cs + 200);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
